// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the dmem_ctrl data-memory sequencer.
// Access sizes, FSM states, grant ids and lane-select helpers live here.
package dmem_ctrl_pkg;

  localparam int unsigned DefaultAw = 16;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzIll  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StMerge,
    StDone
  } state_e;

  typedef enum logic {
    GntC = 1'b0,
    GntD = 1'b1
  } grant_e;

  localparam logic [31:0] ByteLaneMask = 32'h0000_00ff;
  localparam logic [31:0] HalfLaneMask = 32'h0000_ffff;

  // Halves are selected by offset[1] alone; bytes by the full offset.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset, input size_e size);
    return (size == SzHalf) ? {offset[1], 4'b0000} : {offset, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: little-endian load extract/extend and sub-word
// store merge into an existing memory word.
module dmem_lane_unit
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [15:0] lane;

  always_comb begin
    sh        = lane_shift(offset, size);
    lane      = 16'(word >> sh);
    load_data = word;
    merged    = word;
    unique case (size)
      SzByte: begin
        load_data = {{24{~uns & lane[7]}}, lane[7:0]};
        merged    = (word & ~(ByteLaneMask << sh)) | ({24'd0, wdata[7:0]} << sh);
      end
      SzHalf: begin
        load_data = {{16{~uns & lane[15]}}, lane[15:0]};
        merged    = (word & ~(HalfLaneMask << sh)) | ({16'd0, wdata} << sh);
      end
      SzWord, SzIll: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (core C, debug D) round-robin sequencer for a word-wide synchronous data memory.
// Optional saturating access counters are enabled by defining DMEM_CTRL_STATS_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned AW = DefaultAw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [1:0]    c_size,
  input  logic          c_uns,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_rsp_valid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_uns,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_rsp_valid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   stat_cacc,
  output logic [15:0]   stat_dacc,
  output logic [15:0]   stat_err,
  output logic [15:0]   stat_cont
);

  state_e      state_q;
  grant_e      last_grant_q, gid_q;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic        grant_c;
  grant_e      grant_id;
  logic        sel_we, sel_uns, sel_err;
  size_e       sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] load_data, merged;

  always_comb begin
    grant_c = c_req;
    if (c_req && d_req) grant_c = (last_grant_q == GntD);
    grant_id  = grant_c ? GntC : GntD;
    sel_we    = grant_c ? c_we : d_we;
    sel_uns   = grant_c ? c_uns : d_uns;
    sel_size  = size_e'(grant_c ? c_size : d_size);
    sel_addr  = grant_c ? c_addr : d_addr;
    sel_wdata = grant_c ? c_wdata : d_wdata;
    sel_err   = (sel_size == SzIll)
             || (sel_size == SzHalf && sel_addr[0])
             || (sel_size == SzWord && sel_addr[1:0] != 2'b00)
             || ((sel_addr >> (AW + 2)) != 32'd0);
  end

  dmem_lane_unit u_lane (
    .word      (mem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GntD;
      gid_q        <= GntD;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SzByte;
      off_q        <= 2'b00;
      wdata_q      <= 16'd0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= 32'd0;
      c_rsp_valid  <= 1'b0;
      d_rsp_valid  <= 1'b0;
      c_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
      c_err        <= 1'b0;
      d_err        <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      c_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      c_rdata     <= 32'd0;
      d_rdata     <= 32'd0;
      c_err       <= 1'b0;
      d_err       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (c_req || d_req) begin
            last_grant_q <= grant_id;
            gid_q        <= grant_id;
            we_q         <= sel_we;
            uns_q        <= sel_uns;
            size_q       <= sel_size;
            off_q        <= sel_addr[1:0];
            wdata_q      <= sel_wdata[15:0];
            if (sel_err) begin
              state_q     <= StDone;
              c_rsp_valid <= grant_c;
              d_rsp_valid <= !grant_c;
              c_err       <= grant_c;
              d_err       <= !grant_c;
            end else begin
              state_q  <= StIssue;
              mem_addr <= sel_addr[AW+1:2];
              if (sel_we && sel_size == SzWord) begin
                mem_we    <= 1'b1;
                mem_wdata <= sel_wdata;
              end
            end
          end
        end
        StIssue: begin
          if (we_q && size_q == SzWord) begin
            state_q     <= StDone;
            c_rsp_valid <= (gid_q == GntC);
            d_rsp_valid <= (gid_q == GntD);
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (we_q) begin
            state_q   <= StMerge;
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state_q     <= StDone;
            c_rsp_valid <= (gid_q == GntC);
            d_rsp_valid <= (gid_q == GntD);
            c_rdata     <= (gid_q == GntC) ? load_data : 32'd0;
            d_rdata     <= (gid_q == GntD) ? load_data : 32'd0;
          end
        end
        StMerge: begin
          state_q     <= StDone;
          c_rsp_valid <= (gid_q == GntC);
          d_rsp_valid <= (gid_q == GntD);
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DMEM_CTRL_STATS_EN
  logic c_busy, d_busy, cont;

  // A port is busy when it is being granted now or owns the in-flight transaction.
  always_comb begin
    c_busy = (state_q == StIdle) ? (c_req && grant_c) : (gid_q == GntC);
    d_busy = (state_q == StIdle) ? (d_req && !grant_c) : (gid_q == GntD);
    cont   = (c_req && !c_busy) || (d_req && !d_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cacc <= 16'd0;
      stat_dacc <= 16'd0;
      stat_err  <= 16'd0;
      stat_cont <= 16'd0;
    end else begin
      if (c_rsp_valid && stat_cacc != 16'hffff) stat_cacc <= stat_cacc + 16'd1;
      if (d_rsp_valid && stat_dacc != 16'hffff) stat_dacc <= stat_dacc + 16'd1;
      if ((c_err || d_err) && stat_err != 16'hffff) stat_err <= stat_err + 16'd1;
      if (cont && stat_cont != 16'hffff) stat_cont <= stat_cont + 16'd1;
    end
  end
`else
  assign stat_cacc = 16'd0;
  assign stat_dacc = 16'd0;
  assign stat_err  = 16'd0;
  assign stat_cont = 16'd0;
`endif

endmodule
